// File: rtl/pwm_preconditioner_if.sv
// Per-transducer sample stream from the silencer into the PWM preconditioner.
// One duty/phase pair per clock while DIN_VALID is high.
interface pwm_preconditioner_if #(
    parameter int WIDTH = 13
);
    logic             DIN_VALID;
    logic [WIDTH-1:0] DUTY;
    logic [WIDTH-1:0] PHASE;

    modport master (output DIN_VALID, output DUTY, output PHASE);
    modport slave  (input  DIN_VALID, input  DUTY, input  PHASE);
endinterface

// File: rtl/pwm_preconditioner.sv
// Converts silenced duty/phase into PWM rise/fall edges per transducer and
// commits a whole frame atomically to the generator array.
module pwm_preconditioner #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 249
) (
    input  logic                         CLK,
    input  logic                         RST,
    pwm_preconditioner_if.slave          din,
    input  logic [DEPTH-1:0][WIDTH-1:0]  CYCLE,
    output logic [DEPTH-1:0][WIDTH-1:0]  RISE,
    output logic [DEPTH-1:0][WIDTH-1:0]  FALL,
    output logic                         DOUT_VALID
);
    localparam int IW = $clog2(DEPTH);

    logic [IW-1:0]    idx;
    logic             at_last;

    logic             s0_valid, s0_last;
    logic [IW-1:0]    s0_idx;
    logic [WIDTH-1:0] s0_duty, s0_phase, s0_cyc;

    logic             s1_valid, s1_last;
    logic [IW-1:0]    s1_idx;
    logic [WIDTH:0]   s1_r, s1_f;
    logic [WIDTH-1:0] s1_cyc;

    logic             commit;

    logic [DEPTH-1:0][WIDTH-1:0] shadow_rise;
    logic [DEPTH-1:0][WIDTH-1:0] shadow_fall;

    logic [WIDTH-1:0] half_cyc, duty_e, phase_e;
    logic [WIDTH:0]   duty_p1, r_calc, f_calc;
    logic [WIDTH-1:0] rise_w, fall_w;

    assign at_last = (idx == IW'(DEPTH - 1));

    always_comb begin
        half_cyc = s0_cyc >> 1;
        duty_e   = (s0_duty > half_cyc) ? half_cyc : s0_duty;
        phase_e  = (s0_phase >= s0_cyc) ? '0 : s0_phase;
        duty_p1  = {1'b0, duty_e} + (WIDTH+1)'(1);
        // r may go negative; bit WIDTH acts as the sign
        r_calc   = {1'b0, phase_e} - ({1'b0, duty_e} >> 1);
        f_calc   = {1'b0, phase_e} + (duty_p1 >> 1);
    end

    always_comb begin
        rise_w = s1_r[WIDTH] ? WIDTH'(s1_r + {1'b0, s1_cyc})
                             : s1_r[WIDTH-1:0];
        fall_w = (s1_f >= {1'b0, s1_cyc}) ? WIDTH'(s1_f - {1'b0, s1_cyc})
                                          : s1_f[WIDTH-1:0];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            idx        <= '0;
            s0_valid   <= 1'b0;
            s0_last    <= 1'b0;
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            commit     <= 1'b0;
            DOUT_VALID <= 1'b0;
            RISE       <= '0;
            FALL       <= '0;
        end else begin
            s0_valid <= din.DIN_VALID;
            s0_last  <= din.DIN_VALID & at_last;
            if (din.DIN_VALID && !at_last)
                idx <= idx + IW'(1);
            else
                idx <= '0;
            s1_valid   <= s0_valid;
            s1_last    <= s0_valid & s0_last;
            commit     <= s1_valid & s1_last;
            DOUT_VALID <= commit;
            // Copies pre-edge shadow; a new frame's entry 0 lands after this
            if (commit) begin
                RISE <= shadow_rise;
                FALL <= shadow_fall;
            end
        end
    end

    always_ff @(posedge CLK) begin
        s0_idx   <= idx;
        s0_duty  <= din.DUTY;
        s0_phase <= din.PHASE;
        s0_cyc   <= CYCLE[idx];
        s1_idx   <= s0_idx;
        s1_r     <= r_calc;
        s1_f     <= f_calc;
        s1_cyc   <= s0_cyc;
        if (s1_valid) begin
            shadow_rise[s1_idx] <= rise_w;
            shadow_fall[s1_idx] <= fall_w;
        end
    end
endmodule

// File: doc/pwm_preconditioner.md
# pwm_preconditioner

Downstream neighbour of the silencer. Consumes the silencer's per-transducer output stream (DUTY_S/PHASE_S, one transducer per clock), converts each duty/phase pair into PWM rise and fall edge times within that transducer's cycle, and collects a complete frame in a shadow buffer. On frame completion it commits all DEPTH rise/fall pairs atomically to the PWM generator array, so the generators never see a half-updated frame.

## Interface
- WIDTH, 13, bit width of cycle, duty, phase, rise, fall
- DEPTH, 249, number of transducers per frame

- CLK  in  1  system clock, 20.48 MHz domain, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- DIN_VALID  in  1  high for each cycle carrying one transducer sample; a frame is DEPTH contiguous high cycles
- DUTY  in  WIDTH  silenced duty of the current transducer (from silencer DUTY_S)
- PHASE  in  WIDTH  silenced phase of the current transducer (from silencer PHASE_S)
- CYCLE  in  WIDTH x DEPTH  per-transducer PWM period; static during a frame
- RISE  out  WIDTH x DEPTH  committed rise time per transducer
- FALL  out  WIDTH x DEPTH  committed fall time per transducer
- DOUT_VALID  out  1  one-cycle pulse in the cycle RISE/FALL hold a newly committed frame

## Operation
- Index counter idx (ceil(log2 DEPTH) bits): each DIN_VALID=1 cycle samples DUTY, PHASE and CYCLE[idx], then idx increments; at idx=DEPTH-1 the sample is tagged last and idx returns to 0.
- DIN_VALID low with idx≠0 (broken frame): idx returns to 0, samples already in flight still write the shadow buffer, but no commit occurs for that frame.
- Sanitising (stage 1): duty_e = min(DUTY, CYCLE[idx]>>1); phase_e = (PHASE >= CYCLE[idx]) ? 0 : PHASE.
- Stage 1 arithmetic, WIDTH+1-bit signed: r = phase_e − (duty_e>>1); f = phase_e + ((duty_e+1)>>1).
- Stage 2 wrap: rise = r<0 ? r+cycle : r; fall = f>=cycle ? f−cycle : f; both truncated to WIDTH bits and always < cycle. fall−rise ≡ duty_e (mod cycle). duty_e=0 gives rise==fall (generator output off).
- Stage 2 writes shadow_rise[i]/shadow_fall[i]; if tagged last, sets commit flag.
- Commit: on the edge following commit flag, RISE/FALL ← shadow arrays (all DEPTH entries), DOUT_VALID=1 for that cycle only.
- Back-to-back frames with zero gap supported: the commit edge copies pre-edge shadow contents, so entry 0 of the next frame written on the same edge does not corrupt the committed frame.
- No backpressure; block accepts a sample every cycle.

## Timing
- Pipeline: input sample edge E0 → stage 1 register E1 → shadow write E2 → commit E3.
- Last sample sampled at edge E0 ⇒ RISE/FALL updated and DOUT_VALID high in the cycle after E3; latency 3 clocks from last sample to committed output.
- DOUT_VALID width exactly 1 cycle; minimum spacing between pulses DEPTH cycles.
- Reset values: RISE[*]=0, FALL[*]=0, DOUT_VALID=0, idx=0, pipeline valid/last flags 0, commit flag 0; shadow contents don't-care.
- RST asserted mid-frame or during pipeline drain: frame discarded, no DOUT_VALID, RISE/FALL return to 0; first frame after RST deasserts is accepted normally.
- RST and commit on the same edge: reset wins.
- CYCLE change mid-frame: already-processed entries keep old-cycle values; no error detection.

## Test plan
- Basic: all CYCLE=4096, DUTY=2000, PHASE=1000 for DEPTH samples -> DOUT_VALID 3 clocks after last sample, all RISE=0, FALL=2000.
- Wrap both sides: CYCLE=4000; entry 0 DUTY=1000 PHASE=100 -> RISE=3600 FALL=600; entry 1 DUTY=401 PHASE=3900 -> RISE=3700 FALL=101; odd DUTY=3 PHASE=10 -> RISE=9 FALL=12.
- Sanitising: CYCLE=2000, DUTY=1500 PHASE=0 -> RISE=1500 FALL=500; DUTY=0 PHASE=2500 -> RISE=FALL=0.
- Atomic commit / back-to-back: two frames (A all DUTY=100, B all DUTY=200, PHASE=500, CYCLE=4096) with no gap -> exactly two DOUT_VALID pulses DEPTH cycles apart; during the first, every entry equals frame A (RISE=450 FALL=550), during the second frame B (RISE=400 FALL=600); no mixed values at any cycle.
- Broken frame: DIN_VALID drops after 100 samples, then a full frame follows -> only one DOUT_VALID, outputs match the full frame.
- Reset: RST pulsed 1 cycle after last sample of a frame -> no DOUT_VALID, RISE/FALL all 0; next full frame commits correctly. Randomised regression: 100 frames, random CYCLE in [2000,8000], DUTY ≤ CYCLE/2, PHASE < CYCLE, checked against reference model.
